bus_arbiter: RTL and testbench

- Parametrised shared-memory arbiter for the openmips core.
- Merges N_CH independent SRAM-like requesters onto one variable-latency memory port. In the default use these are instruction fetch and data MEM stage; further ports (e.g. a DMA) can be added.
- Generates per-channel stall requests for ctrl. Honours the pipeline flush.
- Replaces the split rom/ram ports at the top level.

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_pick.sv | 52 +++++
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings, arbitration
// modes and the default ack timeout.
package bus_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam int ARB_FIXED           = 0;
    localparam int ARB_RR              = 1;
    localparam int ARB_DEFAULT_TIMEOUT = 255;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    // Counter must be able to hold TIMEOUT-1 at least.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational grant selection: fixed priority (lowest index) or round-robin
// starting one past the previous winner.
module bus_arbiter_pick
    import bus_arbiter_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    input  arb_mode_e        mode,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    localparam int SUM_W = IDX_W + 1;

    genvar gi, gj;

    logic [IDX_W-1:0] start;
    logic [N_CH-1:0]  rot;
    logic [N_CH-1:0]  low_hot;
    logic [IDX_W-1:0] offset;
    logic [SUM_W-1:0] sum;

    assign start = (mode == MODE_FIXED)                ? '0 :
                   (last_grant == IDX_W'(N_CH - 1))    ? '0 :
                   last_grant + IDX_W'(1);

    // Rotate so the search origin sits at bit 0, then isolate the lowest set bit.
    assign rot     = N_CH'({req, req} >> start);
    assign low_hot = rot & (~rot + N_CH'(1));

    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_bit
            logic [N_CH-1:0] hit;
            for (gj = 0; gj < N_CH; gj++) begin : g_ch
                if (((gj >> gi) & 1) != 0) begin : g_on
                    assign hit[gj] = low_hot[gj];
                end else begin : g_off
                    assign hit[gj] = 1'b0;
                end
            end
            assign offset[gi] = |hit;
        end
    endgenerate

    assign sum   = SUM_W'(start) + SUM_W'(offset);
    assign grant = (sum >= SUM_W'(N_CH)) ? IDX_W'(sum - SUM_W'(N_CH)) : IDX_W'(sum);
    assign valid = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Merges N_CH SRAM-like requesters onto one variable-latency memory port,
// with per-channel stall requests, flush kill and ack timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_CH     = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int TIMEOUT  = ARB_DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [N_CH-1:0]          req_ce_i,
    input  logic [N_CH-1:0]          req_we_i,
    input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [N_CH*DATA_W-1:0]   req_wdata_i,
    input  logic [N_CH*DATA_W/8-1:0] req_sel_i,
    output logic [DATA_W-1:0]        resp_rdata_o,
    output logic [N_CH-1:0]          resp_ack_o,
    output logic [N_CH-1:0]          resp_err_o,
    output logic [N_CH-1:0]          stallreq_o,
    output logic                     mem_ce_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic [DATA_W/8-1:0]      mem_sel_o,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    input  logic                     mem_ack_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam arb_mode_e MODE = (ARB_MODE == ARB_RR) ? MODE_RR : MODE_FIXED;

    genvar gi;

    logic [ADDR_W-1:0] ch_addr  [N_CH];
    logic [DATA_W-1:0] ch_wdata [N_CH];
    logic [SEL_W-1:0]  ch_sel   [N_CH];

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
            assign ch_sel[gi]   = req_sel_i[gi*SEL_W +: SEL_W];
        end
    endgenerate

    logic [0:0]        state_reg, state_next;
    logic [IDX_W-1:0]  grant_reg, grant_next;
    logic [IDX_W-1:0]  last_grant_reg, last_grant_next;
    logic              kill_reg, kill_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              mem_ce_reg, mem_ce_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [SEL_W-1:0]  mem_sel_reg, mem_sel_next;
    logic [DATA_W-1:0] resp_rdata_reg, resp_rdata_next;
    logic [N_CH-1:0]   resp_ack_reg, resp_ack_next;
    logic [N_CH-1:0]   resp_err_reg, resp_err_next;

    logic [IDX_W-1:0]  pick_grant;
    logic              pick_valid;
    logic              timeout_hit;
    logic              quiet;

    bus_arbiter_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_ce_i),
        .last_grant (last_grant_reg),
        .mode       (MODE),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
    // A flush in the completion cycle cancels the response just like an earlier one.
    assign quiet       = kill_reg | flush_i;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        kill_next       = kill_reg;
        cnt_next        = cnt_reg;
        mem_ce_next     = mem_ce_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_sel_next    = mem_sel_reg;
        resp_rdata_next = '0;
        resp_ack_next   = '0;
        resp_err_next   = '0;
        case (state_reg)
            ARB_IDLE: begin
                if (!flush_i && pick_valid) begin
                    state_next      = ARB_BUSY;
                    grant_next      = pick_grant;
                    last_grant_next = pick_grant;
                    cnt_next        = '0;
                    mem_ce_next     = 1'b1;
                    mem_we_next     = req_we_i[pick_grant];
                    mem_addr_next   = ch_addr[pick_grant];
                    mem_wdata_next  = ch_wdata[pick_grant];
                    mem_sel_next    = ch_sel[pick_grant];
                end
            end
            ARB_BUSY: begin
                cnt_next  = cnt_reg + CNT_W'(1);
                kill_next = quiet;
                // The bus cannot abort, so a killed access still waits for its ack.
                if (mem_ack_i || timeout_hit) begin
                    state_next  = ARB_IDLE;
                    kill_next   = 1'b0;
                    mem_ce_next = 1'b0;
                    mem_we_next = 1'b0;
                    if (!quiet) begin
                        resp_ack_next[grant_reg] = 1'b1;
                        resp_err_next[grant_reg] = ~mem_ack_i;
                        resp_rdata_next = (mem_ack_i && !mem_we_reg) ? mem_rdata_i : '0;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ARB_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(N_CH - 1);
            kill_reg       <= 1'b0;
            cnt_reg        <= '0;
            mem_ce_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_sel_reg    <= '0;
            resp_rdata_reg <= '0;
            resp_ack_reg   <= '0;
            resp_err_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            kill_reg       <= kill_next;
            cnt_reg        <= cnt_next;
            mem_ce_reg     <= mem_ce_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_sel_reg    <= mem_sel_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_ack_reg   <= resp_ack_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    assign stallreq_o   = req_ce_i & ~resp_ack_reg;
    assign resp_rdata_o = resp_rdata_reg;
    assign resp_ack_o   = resp_ack_reg;
    assign resp_err_o   = resp_err_reg;
    assign mem_ce_o     = mem_ce_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign mem_sel_o    = mem_sel_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a fixed-priority and a round-robin instance
// run against a transaction-level reference model of requesters and memory.
module tb_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NC = 3;
    localparam int SW = DW / 8;
    localparam int TO = 15;
    localparam int NU = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush      [NU];
    logic [NC-1:0]    req_ce     [NU];
    logic [NC-1:0]    req_we     [NU];
    logic [NC*AW-1:0] req_addr   [NU];
    logic [NC*DW-1:0] req_wdata  [NU];
    logic [NC*SW-1:0] req_sel    [NU];
    logic [DW-1:0]    resp_rdata [NU];
    logic [NC-1:0]    resp_ack   [NU];
    logic [NC-1:0]    resp_err   [NU];
    logic [NC-1:0]    stallreq   [NU];
    logic             mem_ce     [NU];
    logic             mem_we     [NU];
    logic [AW-1:0]    mem_addr   [NU];
    logic [DW-1:0]    mem_wdata  [NU];
    logic [SW-1:0]    mem_sel    [NU];
    logic [DW-1:0]    mem_rdata  [NU];
    logic             mem_ack    [NU];

    // Instance 0 uses fixed priority, instance 1 round-robin.
    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        bus_arbiter #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .N_CH     (NC),
            .ARB_MODE (gi),
            .TIMEOUT  (TO)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (flush[gi]),
            .req_ce_i     (req_ce[gi]),
            .req_we_i     (req_we[gi]),
            .req_addr_i   (req_addr[gi]),
            .req_wdata_i  (req_wdata[gi]),
            .req_sel_i    (req_sel[gi]),
            .resp_rdata_o (resp_rdata[gi]),
            .resp_ack_o   (resp_ack[gi]),
            .resp_err_o   (resp_err[gi]),
            .stallreq_o   (stallreq[gi]),
            .mem_ce_o     (mem_ce[gi]),
            .mem_we_o     (mem_we[gi]),
            .mem_addr_o   (mem_addr[gi]),
            .mem_wdata_o  (mem_wdata[gi]),
            .mem_sel_o    (mem_sel[gi]),
            .mem_rdata_i  (mem_rdata[gi]),
            .mem_ack_i    (mem_ack[gi])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester side: one outstanding request per channel.
    bit            pend    [NU][NC];
    bit            r_we    [NU][NC];
    logic [AW-1:0] r_addr  [NU][NC];
    logic [DW-1:0] r_wdata [NU][NC];
    logic [SW-1:0] r_sel   [NU][NC];

    // Reference model: the transaction in flight and the expected registered outputs.
    bit            m_busy [NU];
    bit            m_kill [NU];
    int            m_ch   [NU];
    int            m_last [NU];
    int            m_age  [NU];
    int            m_lat  [NU];
    bit            e_ce    [NU];
    bit            e_we    [NU];
    logic [AW-1:0] e_addr  [NU];
    logic [DW-1:0] e_wdata [NU];
    logic [SW-1:0] e_sel   [NU];
    logic [DW-1:0] e_rdata [NU];
    logic [NC-1:0] e_ack   [NU];
    logic [NC-1:0] e_err   [NU];

    function automatic int pick_ch(input int mode, input int last, input logic [NC-1:0] req);
        for (int k = 0; k < NC; k++) begin
            int c;
            c = (mode == 0) ? k : (last + 1 + k) % NC;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic new_req(input int u, input int i);
        pend[u][i]    = 1'b1;
        r_we[u][i]    = 1'($urandom_range(0, 1));
        r_addr[u][i]  = $urandom & 32'hFFFF_FFFC;
        r_wdata[u][i] = $urandom;
        r_sel[u][i]   = 4'($urandom_range(1, 15));
    endtask

    task automatic drive_reqs(input int u);
        for (int i = 0; i < NC; i++) begin
            req_ce[u][i]              = pend[u][i];
            req_we[u][i]              = r_we[u][i];
            req_addr[u][i*AW +: AW]   = r_addr[u][i];
            req_wdata[u][i*DW +: DW]  = r_wdata[u][i];
            req_sel[u][i*SW +: SW]    = r_sel[u][i];
        end
    endtask

    task automatic reset_model();
        for (int u = 0; u < NU; u++) begin
            flush[u] = 1'b0;  mem_ack[u] = 1'b0;  mem_rdata[u] = '0;
            m_busy[u] = 1'b0; m_kill[u] = 1'b0;   m_last[u] = NC - 1;
            m_ch[u] = 0;      m_age[u] = 0;       m_lat[u] = 0;
            e_ce[u] = 1'b0;   e_we[u] = 1'b0;     e_addr[u] = '0;
            e_wdata[u] = '0;  e_sel[u] = '0;      e_rdata[u] = '0;
            e_ack[u] = '0;    e_err[u] = '0;
            for (int i = 0; i < NC; i++) begin
                pend[u][i] = 1'b0; r_we[u][i] = 1'b0; r_addr[u][i] = '0;
                r_wdata[u][i] = '0; r_sel[u][i] = '0;
            end
            drive_reqs(u);
        end
    endtask

    task automatic check_zero(input int u);
        chk($sformatf("u%0d rst ce", u),    mem_ce[u],     '0);
        chk($sformatf("u%0d rst we", u),    mem_we[u],     '0);
        chk($sformatf("u%0d rst addr", u),  mem_addr[u],   '0);
        chk($sformatf("u%0d rst wdata", u), mem_wdata[u],  '0);
        chk($sformatf("u%0d rst sel", u),   mem_sel[u],    '0);
        chk($sformatf("u%0d rst ack", u),   resp_ack[u],   '0);
        chk($sformatf("u%0d rst err", u),   resp_err[u],   '0);
        chk($sformatf("u%0d rst rdata", u), resp_rdata[u], '0);
    endtask

    task automatic check_regs(input int u);
        chk($sformatf("u%0d mem_ce", u),     mem_ce[u],     e_ce[u]);
        chk($sformatf("u%0d mem_we", u),     mem_we[u],     e_we[u]);
        chk($sformatf("u%0d resp_ack", u),   resp_ack[u],   e_ack[u]);
        chk($sformatf("u%0d resp_err", u),   resp_err[u],   e_err[u]);
        chk($sformatf("u%0d resp_rdata", u), resp_rdata[u], e_rdata[u]);
        if (e_ce[u]) begin
            chk($sformatf("u%0d mem_addr", u),  mem_addr[u],  e_addr[u]);
            chk($sformatf("u%0d mem_wdata", u), mem_wdata[u], e_wdata[u]);
            chk($sformatf("u%0d mem_sel", u),   mem_sel[u],   e_sel[u]);
        end
        if (e_ack[u] != '0)
            $display("u%0d txn done: ack=%b err=%b rdata=%h", u, e_ack[u], e_err[u], e_rdata[u]);
    endtask

    task automatic stimulus(input int u);
        for (int i = 0; i < NC; i++) begin
            if (e_ack[u][i]) pend[u][i] = 1'b0;
            if (!pend[u][i] && $urandom_range(0, 99) < 60) new_req(u, i);
        end
        drive_reqs(u);
        flush[u] = ($urandom_range(0, 9) == 0);
        if (m_busy[u]) begin
            mem_ack[u]   = (m_age[u] == m_lat[u]);
            mem_rdata[u] = $urandom;
        end else begin
            mem_ack[u]   = 1'b0;
            mem_rdata[u] = '0;
        end
    endtask

    // Predicts what the next clock edge produces from this cycle's inputs.
    task automatic model_next(input int u);
        logic [NC-1:0] reqv;
        for (int i = 0; i < NC; i++) reqv[i] = pend[u][i];
        e_ack[u]   = '0;
        e_err[u]   = '0;
        e_rdata[u] = '0;
        if (m_busy[u]) begin
            bit quiet;
            quiet = m_kill[u] || flush[u];
            if (mem_ack[u] || (m_age[u] + 1 == TO)) begin
                if (!quiet) begin
                    e_ack[u][m_ch[u]] = 1'b1;
                    e_err[u][m_ch[u]] = !mem_ack[u];
                    e_rdata[u] = (mem_ack[u] && !e_we[u]) ? mem_rdata[u] : '0;
                end
                m_busy[u] = 1'b0;
                m_kill[u] = 1'b0;
                e_ce[u]   = 1'b0;
                e_we[u]   = 1'b0;
            end else begin
                m_age[u]++;
                m_kill[u] = quiet;
            end
        end else if (!flush[u]) begin
            int g;
            int r;
            g = pick_ch(u, m_last[u], reqv);
            if (g >= 0) begin
                r = $urandom_range(0, 11);
                m_lat[u]   = (r < 8) ? r % 4 : (r < 10) ? TO - 1 : 1000;
                m_busy[u]  = 1'b1;
                m_ch[u]    = g;
                m_last[u]  = g;
                m_age[u]   = 0;
                e_ce[u]    = 1'b1;
                e_we[u]    = r_we[u][g];
                e_addr[u]  = r_addr[u][g];
                e_wdata[u] = r_wdata[u][g];
                e_sel[u]   = r_sel[u][g];
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < NU; u++) check_regs(u);
            for (int u = 0; u < NU; u++) stimulus(u);
            #1;
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("u%0d stallreq", u), stallreq[u], req_ce[u] & ~e_ack[u]);
                model_next(u);
            end
        end
    endtask

    initial begin
        int tries;
        rst = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) check_zero(u);
        #2 rst = 1'b1;

        run_cycles(1500);

        // Asynchronous reset in the middle of a round-robin access.
        tries = 0;
        while (!m_busy[1] && tries < 100) begin
            run_cycles(1);
            tries++;
        end
        @(posedge clk);
        #3;
        chk("u1 ce before reset", mem_ce[1], 1'b1);
        rst = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) check_zero(u);
        reset_model();
        @(posedge clk);
        #3 rst = 1'b1;
        // Every channel requests at once after reset; round-robin must start at ch0.
        for (int u = 0; u < NU; u++)
            for (int i = 0; i < NC; i++) new_req(u, i);
        run_cycles(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
